// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int DIGITS = 8;
    localparam int WORD_W = 32;
    // Width of one display digit; the source tag occupies the leftmost one.
    localparam int NIB_W  = WORD_W / DIGITS;

    localparam logic [WORD_W-1:0] IDLE_DATA_DEFAULT = 32'h0000_0000;

    function automatic int src_idx_w(input int nreq);
        if (nreq > 2) begin
            return $clog2(nreq);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational rotating priority encoder: picks the first requester after
// i_cur_src (wrapping), so the most recently served source has lowest priority.
module seg7_rr_pick
    import seg7_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]            i_req,
    input  logic [src_idx_w(NREQ)-1:0] i_cur_src,
    output logic [src_idx_w(NREQ)-1:0] o_sel,
    output logic                       o_any
);

    localparam int SW = src_idx_w(NREQ);

    logic [SW:0]   w_sum;
    logic [SW-1:0] w_idx;

    // Scan offsets 1..NREQ from the last grant; the nearest set bit wins.
    always_comb begin
        o_sel = i_cur_src;
        o_any = 1'b0;
        w_sum = '0;
        w_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, i_cur_src} + (SW+1)'(k);
            if (w_sum >= (SW+1)'(NREQ)) begin
                w_sum = w_sum - (SW+1)'(NREQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[SW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_sel = w_idx;
                o_any = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/seg7_display_sched.sv
// Round-robin scheduler sharing one 8-digit display among NREQ sources.
// Optional build macro SEG7_SCHED_TAG_EN puts the source index in the leftmost digit.
module seg7_display_sched
    import seg7_pkg::*;
#(
    parameter int                NREQ      = 4,
    parameter int                DWELL     = 50_000_000,
    parameter int                BLANK_CYC = 1_000_000,
    parameter logic [WORD_W-1:0] IDLE_DATA = IDLE_DATA_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WORD_W-1:0]     req_data,
    output logic [NREQ-1:0]            grant,
    output logic [NREQ-1:0]            ack,
    output logic [WORD_W-1:0]          num_data,
    output logic [src_idx_w(NREQ)-1:0] cur_src,
    output logic                       busy
);

    localparam int SW      = src_idx_w(NREQ);
    localparam int MAX_CNT = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int TW      = $clog2(MAX_CNT + 1);

    localparam logic [TW-1:0]   DWELL_LD  = TW'(DWELL - 1);
    localparam logic [TW-1:0]   BLANK_LD  = (BLANK_CYC > 0) ? TW'(BLANK_CYC - 1) : '0;
    localparam logic [SW-1:0]   LAST_SRC  = SW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};
    // With no gap configured the end of a dwell returns straight to arbitration.
    localparam state_t          END_STATE = (BLANK_CYC == 0) ? IDLE : BLANK;
    localparam logic            END_BUSY  = (BLANK_CYC == 0) ? 1'b0 : 1'b1;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_ack;
    logic [WORD_W-1:0] r_num;
    logic [SW-1:0]     r_cur;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [NREQ-1:0]   w_ack_nxt;
    logic [WORD_W-1:0] w_num_nxt;
    logic [SW-1:0]     w_cur_nxt;
    logic              w_busy_nxt;

    logic [SW-1:0]     w_sel;
    logic              w_any;
    logic [WORD_W-1:0] w_words [NREQ];
    logic [WORD_W-1:0] w_pick_word;
    logic [WORD_W-1:0] w_show_word;

    seg7_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req     (req),
        .i_cur_src (r_cur),
        .o_sel     (w_sel),
        .o_any     (w_any)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign w_words[gi] = req_data[gi*WORD_W +: WORD_W];
    end

    assign w_pick_word = w_words[w_sel];

`ifdef SEG7_SCHED_TAG_EN
    assign w_show_word = {NIB_W'(w_sel), w_pick_word[WORD_W-NIB_W-1:0]};
`else
    assign w_show_word = w_pick_word;
`endif

    // Next-state and next-output logic for the IDLE/SHOW/BLANK sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        w_num_nxt   = r_num;
        w_cur_nxt   = r_cur;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SHOW;
                    w_timer_nxt = DWELL_LD;
                    w_grant_nxt = ONE_HOT0 << w_sel;
                    w_num_nxt   = w_show_word;
                    w_cur_nxt   = w_sel;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_grant_nxt = '0;
                    w_num_nxt   = IDLE_DATA;
                    w_busy_nxt  = 1'b0;
                end
            end
            SHOW: begin
                // A withdrawn request ends the dwell early and suppresses ack.
                if (!req[r_cur] || (r_timer == '0)) begin
                    w_state_nxt = END_STATE;
                    w_timer_nxt = BLANK_LD;
                    w_grant_nxt = '0;
                    w_num_nxt   = IDLE_DATA;
                    w_busy_nxt  = END_BUSY;
                    if (req[r_cur]) begin
                        w_ack_nxt = ONE_HOT0 << r_cur;
                    end else begin
                        w_ack_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            BLANK: begin
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
                w_grant_nxt = '0;
                w_num_nxt   = IDLE_DATA;
                w_cur_nxt   = LAST_SRC;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves the search pointer on the last source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_num   <= IDLE_DATA;
            r_cur   <= LAST_SRC;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_num   <= w_num_nxt;
            r_cur   <= w_cur_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign grant    = r_grant;
    assign ack      = r_ack;
    assign num_data = r_num;
    assign cur_src  = r_cur;
    assign busy     = r_busy;

endmodule

// File: doc/seg7_display_sched.md
Name: seg7_display_sched

Overview:
Round-robin scheduler that shares the single 8-digit seven-segment display between NREQ requesters (cube pattern index, frame counter, debug words, ...). It grants one requester at a time and latches that requester's 32-bit word. It holds the word for a fixed dwell time, then inserts a blank gap before the next grant. Its num_data output drives the display scanner's 32-bit num_data input directly.

Parameters:
NREQ, 4, number of requesters; 2..16
DWELL, 50_000_000, cycles each granted word is shown; >=1
BLANK_CYC, 1_000_000, cycles of IDLE_DATA between grants; 0 disables the gap
IDLE_DATA, 32'h0000_0000, word shown when nothing is granted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  NREQ  level request per source; held until ack or withdrawn
req_data  in  NREQ*32  source i word at bits [32*i+31:32*i]
grant  out  NREQ  one-hot (or zero); high while that source is displayed
ack  out  NREQ  one-cycle pulse: source's word completed its full dwell
num_data  out  32  word to display scanner
cur_src  out  max(1,$clog2(NREQ))  index of last granted source
busy  out  1  high in SHOW or BLANK

Behaviour:
- One clock; reset is asynchronous and active-high. Reset may assert at any time, including mid-SHOW.
- Reset values: state=IDLE, num_data=IDLE_DATA, grant=0, ack=0, cur_src=NREQ-1 (first search starts at 0), busy=0, timer=0.
- All outputs are registered.
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - If req!=0, pick the first set bit searching cur_src+1, cur_src+2, ... with wrap modulo NREQ.
  - On the next edge: grant[sel]=1, num_data=req_data[sel] (snapshot), cur_src=sel, timer=DWELL-1, state=SHOW.
  - Latency from req to grant/num_data is 1 cycle.
- SHOW:
  - num_data is frozen; req_data changes are ignored.
  - Timer decrements each cycle. grant stays high exactly DWELL cycles.
  - When timer==0 and req[cur_src] is still 1: grant=0, ack[cur_src]=1 for one cycle, num_data=IDLE_DATA. Go to BLANK with timer=BLANK_CYC-1, or to IDLE if BLANK_CYC==0.
  - If req[cur_src] drops before the dwell completes (abort): on the next edge grant=0, no ack, num_data=IDLE_DATA. Go to BLANK, or IDLE if BLANK_CYC==0. Abort takes precedence when it coincides with timer==0.
- BLANK:
  - num_data=IDLE_DATA, grant=0. Timer decrements.
  - At timer==0, go to IDLE. Arbitration happens in IDLE, so the next grant is BLANK_CYC+1 cycles after ack.
- A sole continuous requester is re-granted after every gap. Other requesters are served in rotating order, so there is no starvation.
- Timer width is $clog2(max(DWELL,BLANK_CYC)+1). There are no overflow paths.
- Requesters are expected to drop req within one cycle of ack. A req still high in IDLE is treated as a new request.

Optional Feature:
SEG7_SCHED_TAG_EN
- Defined: in SHOW, num_data[31:28] = cur_src (zero-extended to 4 bits), so the leftmost digit identifies the source. num_data[27:0] = req_data[sel][27:0]. IDLE_DATA is unaffected.
- Undefined: the full 32-bit snapshot is shown.

Decomposition:
- Package seg7_pkg holds:
  - state enum {IDLE, SHOW, BLANK}
  - DIGITS=8 and WORD_W=32
  - the default IDLE_DATA constant
  - a function for source index width
- One sub-module, seg7_rr_pick: a combinational rotating priority encoder.
  - Inputs: req, cur_src.
  - Outputs: sel index, any.
  - It is reusable by other shared-resource arbiters in the cube design.

Test Plan:
All scenarios use NREQ=4, DWELL=8, BLANK_CYC=2, IDLE_DATA=0.
- Reset: assert rst asynchronously mid-cycle -> immediately num_data=0, grant=0, ack=0, busy=0, cur_src=3.
- Single source: req[1]=1 with data 0x12345678 from cycle 0 ->
  - grant=4'b0010 and num_data=0x12345678 in cycles 1..8
  - ack[1] in cycle 9 with num_data=0
  - BLANK in cycles 9..10, IDLE in cycle 11
  - re-grant in cycle 12 if req[1] is still high
- Rotation: req=4'b0101 held throughout -> grant order 0, 2, 0, 2, ... with cur_src matching; each source is shown 8 cycles.
- Snapshot: change req_data[0] from 0xAAAA0000 to 0xBBBB0000 in cycle 4 of its dwell -> num_data stays 0xAAAA0000 until grant ends.
- Abort: drop req[2] in cycle 3 of SHOW -> grant=0 on the next edge, no ack, BLANK for 2 cycles.
  - Also assert rst mid-SHOW -> all outputs return to reset values with no ack.
- With SEG7_SCHED_TAG_EN defined, source 3 with data 0x0FFFFFFF -> num_data=0x3FFFFFFF during SHOW.
